frame_sum_accumulator: RTL

Downstream consumer of the 4-bit ripple adder (`RA`). It captures each adder result `{COUT, SUM}` as a 5-bit value through a valid/ready handshake and accumulates a frame of `N_SAMPLES` results into a wider running total. When the frame is complete, it presents the total and a sticky overflow flag to the next stage through a second valid/ready handshake.

---
 rtl/frame_sum_accumulator.sv | 108 ++++++++++
 1 files changed

// File: rtl/frame_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : frame_sum_accumulator
// Brief    : Accumulates N_SAMPLES 5-bit ripple-adder results {COUT,SUM} per
//            frame and hands the total plus a sticky overflow flag downstream.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sum_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLEAR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       SUM,
    input  logic             COUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] ACC,
    output logic             OVF,
    output logic [3:0]       COUNT
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [3:0] c_last_count = 4'(N_SAMPLES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [3:0]       r_count;
    logic [3:0]       w_count_nxt;
    logic [ACC_W:0]   w_sum;
    logic [3:0]       w_count_inc;

    // One spare MSB captures the carry out of the accumulator's top bit.
    assign w_sum       = {1'b0, r_acc} + {{(ACC_W-4){1'b0}}, COUT, SUM};
    assign w_count_inc = r_count + 4'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_count_nxt = r_count;

        // CLEAR wins over both handshakes; any in-flight value or frame is lost.
        if (CLEAR) begin
            w_state_nxt = ST_ACCUM;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_count_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (IN_VALID) begin
                        w_acc_nxt   = w_sum[ACC_W-1:0];
                        w_ovf_nxt   = r_ovf | w_sum[ACC_W];
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == c_last_count) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (OUT_READY) begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_count_nxt = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACCUM;
                end
            endcase
        end
    end

    assign IN_READY  = (r_state == ST_ACCUM);
    assign OUT_VALID = (r_state == ST_HOLD);
    assign ACC       = r_acc;
    assign OVF       = r_ovf;
    assign COUNT     = r_count;

endmodule
`default_nettype wire
